adpll_lock_ctrl: RTL and testbench

Lock-acquisition and gain-scheduling controller for the 5-bit ADPLL. It samples the reference clock in the system clock domain and watches the phase-error magnitude once per reference edge. It drives the PI filter's `alpha_var`/`beta_var` with wide acquisition gains, then switches to narrow tracking gains once lock is qualified. It reports lock status and re-enters acquisition on loss of lock.

---
 rtl/adpll_ctrl_pkg.sv | 12 +
 rtl/adpll_lock_ctrl_if.sv | 20 ++
 rtl/ref_edge_sync.sv | 14 +
 rtl/adpll_lock_ctrl.sv | 114 +++++++++++
 tb/tb_adpll_lock_ctrl.sv | 136 +++++++++++++
 5 files changed

// File: rtl/adpll_ctrl_pkg.sv
// adpll_ctrl_pkg: shared state encoding, counter width, default gains and helpers for the ADPLL lock controller
package adpll_ctrl_pkg;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, SETTLE = 2'd2, TRACK = 2'd3} state_e;
  localparam logic [4:0] ACQ_ALPHA_DEF = 5'd8;
  localparam logic [4:0] ACQ_BETA_DEF  = 5'd4;
  localparam logic [4:0] TRK_ALPHA_DEF = 5'd2;
  localparam logic [4:0] TRK_BETA_DEF  = 5'd1;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/adpll_lock_ctrl_if.sv
// adpll_lock_ctrl_if: control inputs and gain/status outputs of the lock controller
interface adpll_lock_ctrl_if;
  logic       enable;
  logic       clk_ref;
  logic [4:0] err_mag;
  logic [4:0] alpha_var;
  logic [4:0] beta_var;
  logic       locked;
  logic       unlock_pulse;
  logic       acq_timeout;
  logic [1:0] state;
  modport master (
    output enable, clk_ref, err_mag,
    input  alpha_var, beta_var, locked, unlock_pulse, acq_timeout, state
  );
  modport slave (
    input  enable, clk_ref, err_mag,
    output alpha_var, beta_var, locked, unlock_pulse, acq_timeout, state
  );
endinterface

// File: rtl/ref_edge_sync.sv
// ref_edge_sync: synchronizes clk_ref into clk and emits a one-cycle pulse per rising edge
module ref_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_ref,
  output logic ref_tick
);
  logic [2:0] sync_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], clk_ref};
  end
  assign ref_tick = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/adpll_lock_ctrl.sv
// adpll_lock_ctrl: lock qualification FSM scheduling wide acquisition and narrow tracking PI gains
module adpll_lock_ctrl
  import adpll_ctrl_pkg::*;
#(
  parameter logic [4:0]  ACQ_ALPHA     = ACQ_ALPHA_DEF,
  parameter logic [4:0]  ACQ_BETA      = ACQ_BETA_DEF,
  parameter logic [4:0]  TRK_ALPHA     = TRK_ALPHA_DEF,
  parameter logic [4:0]  TRK_BETA      = TRK_BETA_DEF,
  parameter int unsigned LOCK_THRESH   = 2,
  parameter int unsigned LOCK_CNT      = 16,
  parameter int unsigned SETTLE_TICKS  = 8,
  parameter int unsigned UNLOCK_THRESH = 6,
  parameter int unsigned UNLOCK_CNT    = 4,
  parameter int unsigned ACQ_TIMEOUT   = 200
) (
  input logic               clk,
  input logic               reset,
  adpll_lock_ctrl_if.slave  bus
);
  localparam logic [CNT_W-1:0] LOCK_TH_C   = CNT_W'(LOCK_THRESH);
  localparam logic [CNT_W-1:0] LOCK_CNT_C  = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] SETTLE_C    = CNT_W'(SETTLE_TICKS);
  localparam logic [CNT_W-1:0] UNLOCK_TH_C = CNT_W'(UNLOCK_THRESH);
  localparam logic [CNT_W-1:0] UNLOCK_C    = CNT_W'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0] ACQ_TO_C    = CNT_W'(ACQ_TIMEOUT);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] good_q, good_d, acq_q, acq_d, settle_q, settle_d, bad_q, bad_d;
  logic [CNT_W-1:0] good_n, acq_n, settle_n, bad_n, err8;
  logic [4:0]       alpha_q, alpha_d, beta_q, beta_d;
  logic             locked_q, locked_d, unlock_q, unlock_d, timeout_q, timeout_d, tick;
  ref_edge_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .clk_ref  (bus.clk_ref),
    .ref_tick (tick)
  );
  assign err8     = CNT_W'(bus.err_mag);
  assign good_n   = (err8 <= LOCK_TH_C) ? sat_inc(good_q) : '0;
  assign acq_n    = sat_inc(acq_q);
  assign settle_n = sat_inc(settle_q);
  assign bad_n    = (err8 > UNLOCK_TH_C) ? sat_inc(bad_q) : '0;
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    acq_d     = acq_q;
    settle_d  = settle_q;
    bad_d     = bad_q;
    timeout_d = timeout_q;
    unlock_d  = 1'b0;
    if (!bus.enable) begin
      state_d   = IDLE;
      good_d    = '0;
      acq_d     = '0;
      settle_d  = '0;
      bad_d     = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = ACQ;
        ACQ: if (tick) begin
          timeout_d = timeout_q | (acq_n == ACQ_TO_C);
          good_d    = (good_n == LOCK_CNT_C) ? '0 : good_n;
          acq_d     = (good_n == LOCK_CNT_C) ? '0 : acq_n;
          state_d   = (good_n == LOCK_CNT_C) ? SETTLE : ACQ;
        end
        SETTLE: if (tick) begin
          settle_d = (settle_n == SETTLE_C) ? '0 : settle_n;
          state_d  = (settle_n == SETTLE_C) ? TRACK : SETTLE;
        end
        TRACK: if (tick) begin
          bad_d    = (bad_n == UNLOCK_C) ? '0 : bad_n;
          unlock_d = (bad_n == UNLOCK_C);
          state_d  = (bad_n == UNLOCK_C) ? ACQ : TRACK;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Outputs follow the next state so they change on the same edge as the state register
  assign alpha_d  = (state_d == ACQ) ? ACQ_ALPHA : (state_d == IDLE) ? 5'd0 : TRK_ALPHA;
  assign beta_d   = (state_d == ACQ) ? ACQ_BETA  : (state_d == IDLE) ? 5'd0 : TRK_BETA;
  assign locked_d = (state_d == TRACK);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      good_q    <= '0;
      acq_q     <= '0;
      settle_q  <= '0;
      bad_q     <= '0;
      alpha_q   <= '0;
      beta_q    <= '0;
      locked_q  <= 1'b0;
      unlock_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      acq_q     <= acq_d;
      settle_q  <= settle_d;
      bad_q     <= bad_d;
      alpha_q   <= alpha_d;
      beta_q    <= beta_d;
      locked_q  <= locked_d;
      unlock_q  <= unlock_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.alpha_var    = alpha_q;
  assign bus.beta_var     = beta_q;
  assign bus.locked       = locked_q;
  assign bus.unlock_pulse = unlock_q;
  assign bus.acq_timeout  = timeout_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// tb_adpll_lock_ctrl: directed scenario bench for the ADPLL lock controller
module tb_adpll_lock_ctrl;
  localparam logic [12:0] S_IDLE = {2'd0, 5'd0, 5'd0, 1'b0};
  localparam logic [12:0] S_ACQ  = {2'd1, 5'd8, 5'd4, 1'b0};
  localparam logic [12:0] S_SET  = {2'd2, 5'd2, 5'd1, 1'b0};
  localparam logic [12:0] S_TRK  = {2'd3, 5'd2, 5'd1, 1'b1};
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails = 0;
  int   unlock_seen = 0;
  adpll_lock_ctrl_if bus ();
  adpll_lock_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.unlock_pulse === 1'b1) unlock_seen++;
  function automatic logic [12:0] snap();
    return {bus.state, bus.alpha_var, bus.beta_var, bus.locked};
  endfunction
  task automatic ref_ticks(input int n, input logic [4:0] e);
    repeat (n) begin
      bus.err_mag = e;
      bus.clk_ref = 1'b1;
      repeat (4) @(negedge clk);
      bus.clk_ref = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.clk_ref = 1'b0;
    bus.err_mag = 5'd0;
    repeat (2) @(negedge clk);
    checks++; if (snap() !== S_IDLE) begin fails++; $display("FAIL reset_state: got %h expected %h", snap(), S_IDLE); end
    checks++; if ({bus.unlock_pulse, bus.acq_timeout} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b expected 00", {bus.unlock_pulse, bus.acq_timeout}); end
    reset = 1'b0;
    ref_ticks(50, 5'd1);
    checks++; if (snap() !== S_IDLE) begin fails++; $display("FAIL idle_disabled: got %h expected %h", snap(), S_IDLE); end
  endtask
  task automatic test_acquire();
    bus.enable = 1'b1;
    @(negedge clk);
    checks++; if (snap() !== S_ACQ) begin fails++; $display("FAIL acq_entry: got %h expected %h", snap(), S_ACQ); end
    ref_ticks(15, 5'd1);
    checks++; if (snap() !== S_ACQ) begin fails++; $display("FAIL acq_15_good: got %h expected %h", snap(), S_ACQ); end
    bus.err_mag = 5'd1;
    bus.clk_ref = 1'b1;
    @(negedge clk);
    checks++; if (snap() !== S_ACQ) begin fails++; $display("FAIL tick_edge1: got %h expected %h", snap(), S_ACQ); end
    @(negedge clk);
    checks++; if (snap() !== S_ACQ) begin fails++; $display("FAIL tick_edge2: got %h expected %h", snap(), S_ACQ); end
    @(negedge clk);
    checks++; if (snap() !== S_SET) begin fails++; $display("FAIL tick_edge3_settle: got %h expected %h", snap(), S_SET); end
    @(negedge clk);
    bus.clk_ref = 1'b0;
    repeat (4) @(negedge clk);
    ref_ticks(7, 5'd1);
    checks++; if (snap() !== S_SET) begin fails++; $display("FAIL settle_7: got %h expected %h", snap(), S_SET); end
    ref_ticks(1, 5'd1);
    checks++; if (snap() !== S_TRK) begin fails++; $display("FAIL track_entry: got %h expected %h", snap(), S_TRK); end
  endtask
  task automatic test_unlock();
    unlock_seen = 0;
    ref_ticks(10, 5'd6);
    checks++; if (snap() !== S_TRK) begin fails++; $display("FAIL track_err6: got %h expected %h", snap(), S_TRK); end
    ref_ticks(3, 5'd7);
    checks++; if (snap() !== S_TRK) begin fails++; $display("FAIL track_3_bad: got %h expected %h", snap(), S_TRK); end
    checks++; if (unlock_seen !== 0) begin fails++; $display("FAIL unlock_early: got %0d pulses expected 0", unlock_seen); end
    ref_ticks(1, 5'd7);
    checks++; if (snap() !== S_ACQ) begin fails++; $display("FAIL unlock_to_acq: got %h expected %h", snap(), S_ACQ); end
    checks++; if (unlock_seen !== 1) begin fails++; $display("FAIL unlock_pulse: got %0d pulses expected 1", unlock_seen); end
  endtask
  task automatic test_good_restart();
    ref_ticks(15, 5'd1);
    ref_ticks(1, 5'd3);
    ref_ticks(15, 5'd2);
    checks++; if (snap() !== S_ACQ) begin fails++; $display("FAIL restart_15: got %h expected %h", snap(), S_ACQ); end
    ref_ticks(1, 5'd2);
    checks++; if (snap() !== S_SET) begin fails++; $display("FAIL restart_16: got %h expected %h", snap(), S_SET); end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++; if (snap() !== S_IDLE) begin fails++; $display("FAIL disable_settle: got %h expected %h", snap(), S_IDLE); end
  endtask
  task automatic test_timeout();
    bus.enable = 1'b1;
    @(negedge clk);
    ref_ticks(199, 5'd20);
    checks++; if ({bus.acq_timeout, snap()} !== {1'b0, S_ACQ}) begin fails++; $display("FAIL timeout_199: got %h expected %h", {bus.acq_timeout, snap()}, {1'b0, S_ACQ}); end
    ref_ticks(1, 5'd20);
    checks++; if ({bus.acq_timeout, snap()} !== {1'b1, S_ACQ}) begin fails++; $display("FAIL timeout_200: got %h expected %h", {bus.acq_timeout, snap()}, {1'b1, S_ACQ}); end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++; if ({bus.acq_timeout, snap()} !== {1'b0, S_IDLE}) begin fails++; $display("FAIL timeout_clear: got %h expected %h", {bus.acq_timeout, snap()}, {1'b0, S_IDLE}); end
  endtask
  task automatic test_abort();
    bus.enable = 1'b1;
    @(negedge clk);
    ref_ticks(15, 5'd1);
    bus.err_mag = 5'd1;
    bus.clk_ref = 1'b1;
    repeat (2) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    checks++; if (snap() !== S_IDLE) begin fails++; $display("FAIL abort_on_tick: got %h expected %h", snap(), S_IDLE); end
    @(negedge clk);
    bus.clk_ref = 1'b0;
    repeat (4) @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    ref_ticks(16, 5'd1);
    checks++; if (snap() !== S_SET) begin fails++; $display("FAIL reenter_settle: got %h expected %h", snap(), S_SET); end
    ref_ticks(2, 5'd1);
    reset = 1'b1;
    #1;
    checks++; if (snap() !== S_IDLE) begin fails++; $display("FAIL async_reset: got %h expected %h", snap(), S_IDLE); end
    checks++; if ({bus.unlock_pulse, bus.acq_timeout} !== 2'b00) begin fails++; $display("FAIL async_reset_flags: got %b expected 00", {bus.unlock_pulse, bus.acq_timeout}); end
    @(negedge clk);
    reset = 1'b0;
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_acquire();
    test_unlock();
    test_good_restart();
    test_timeout();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
